// File: rtl/memory_col_ctrl.sv
// -----------------------------------------------------------------------------
// memory_col_ctrl
//
// Request sequencer for a 32-bit word memory built from four 8-bit, 1024-entry
// columns. Word requests (read/write with byte strobes) arrive over a
// valid/ready interface and queue in an in-order request FIFO. The issue stage
// pops one request per clock onto the registered column outputs. Read data
// returns from the columns two clocks after issue and lands in a small
// backpressured response buffer.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/ready request handshake (ready = request FIFO not full)
//   req_we          1 = write, 0 = read
//   req_addr        word address (AW bits)
//   req_wdata       write data, byte i -> column i
//   req_be          byte strobes (ignored for reads)
//   col_addr        shared column address (registered)
//   col_wr_data     column write data, bits [8i+7:8i] -> column i (registered)
//   col_byte_en     per-column write enable, one cycle per write (registered)
//   col_rd_data     concatenated column read data, registered by the columns
//   rsp_valid/ready response handshake
//   rsp_rdata       head of the response buffer
//   busy            any request queued, in flight, buffered, or a write strobe
//                   currently on the columns
//
// Timeline of a read accepted at edge E0: issue at E1, column sample at E2,
// response capture at E3. A read only issues if the response buffer has a
// slot reserved for it, so the buffer can never overflow.
// -----------------------------------------------------------------------------

// Overflow checks for both queues, kept apart from the datapath.
module memory_col_ctrl_chk (
    input logic clk,
    input logic rst_n,
    input logic req_ovf,
    input logic rsp_ovf
);
    a_req_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !req_ovf)
        else $error("request FIFO overflow");

    a_rsp_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !rsp_ovf)
        else $error("response buffer overflow");
endmodule

module memory_col_ctrl #(
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 2,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [3:0]    req_be,
    output logic [AW-1:0] col_addr,
    output logic [31:0]   col_wr_data,
    output logic [3:0]    col_byte_en,
    input  logic [31:0]   col_rd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          busy
);

    localparam int QPW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int QCW = $clog2(REQ_DEPTH + 1);
    localparam int RPW = $clog2(RSP_DEPTH);
    localparam int RCW = $clog2(RSP_DEPTH + 1);
    localparam int SW  = RCW + 2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
    } req_t;

    // Response buffer depth need not be a power of two, so wrap explicitly.
    function automatic logic [RPW-1:0] rsp_ptr_inc(input logic [RPW-1:0] ptr);
        logic [RPW-1:0] nxt;
        if (ptr == RPW'(RSP_DEPTH - 1)) begin
            nxt = {RPW{1'b0}};
        end else begin
            nxt = ptr + RPW'(1);
        end
        return nxt;
    endfunction

    // Request FIFO state
    req_t           req_mem_r [REQ_DEPTH];
    logic [QPW-1:0] req_wr_ptr_r;
    logic [QPW-1:0] req_rd_ptr_r;
    logic [QCW-1:0] req_cnt_r;
    logic           req_ready_r;

    // Issue stage / column outputs
    logic [AW-1:0]  col_addr_r;
    logic [31:0]    col_wr_data_r;
    logic [3:0]     col_byte_en_r;
    logic           rd_p1_r;    // read on the column address lines
    logic           rd_p2_r;    // read data registered inside the columns

    // Response buffer state
    logic [31:0]    rsp_mem_r [RSP_DEPTH];
    logic [RPW-1:0] rsp_wr_ptr_r;
    logic [RPW-1:0] rsp_rd_ptr_r;
    logic [RCW-1:0] rsp_cnt_r;
    logic           rsp_valid_r;
    logic [31:0]    rsp_rdata_r;
    logic           busy_r;

    // Combinational control
    logic           push_s;
    req_t           push_data_s;
    req_t           head_s;
    logic           req_empty_s;
    logic [SW-1:0]  resv_s;
    logic           rd_ok_s;
    logic           issue_s;
    logic           issue_wr_s;
    logic           issue_rd_s;
    logic           cap_s;
    logic           pop_s;
    logic [QCW-1:0] req_cnt_nxt_s;
    logic [RCW-1:0] rsp_cnt_nxt_s;
    logic [RPW-1:0] rsp_rd_ptr_nxt_s;
    logic [31:0]    rsp_head_nxt_s;
    logic           busy_nxt_s;
    logic           req_ovf_s;
    logic           rsp_ovf_s;

    // Handshakes, issue permission and next-state values for registered outputs
    always_comb begin
        push_s      = req_valid && req_ready_r;
        push_data_s = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
        head_s      = req_mem_r[req_rd_ptr_r];
        req_empty_s = (req_cnt_r == QCW'(0));

        // Slots already spoken for: buffered responses plus reads still in the
        // column pipeline. A new read needs one more free slot.
        resv_s  = SW'(rsp_cnt_r) + SW'(rd_p1_r) + SW'(rd_p2_r);
        rd_ok_s = (resv_s < SW'(RSP_DEPTH));

        if (req_empty_s) begin
            issue_s = 1'b0;
        end else if (head_s.we) begin
            issue_s = 1'b1;
        end else begin
            issue_s = rd_ok_s;
        end
        issue_wr_s = issue_s && head_s.we;
        issue_rd_s = issue_s && !head_s.we;

        cap_s = rd_p2_r;
        pop_s = rsp_valid_r && rsp_ready;

        req_cnt_nxt_s = req_cnt_r + QCW'(push_s) - QCW'(issue_s);
        rsp_cnt_nxt_s = rsp_cnt_r + RCW'(cap_s) - RCW'(pop_s);

        if (pop_s) begin
            rsp_rd_ptr_nxt_s = rsp_ptr_inc(rsp_rd_ptr_r);
        end else begin
            rsp_rd_ptr_nxt_s = rsp_rd_ptr_r;
        end

        // The next head is the word being captured only when the buffer is
        // (or becomes) empty, i.e. the write slot is the next read slot.
        if (cap_s && (rsp_wr_ptr_r == rsp_rd_ptr_nxt_s)) begin
            rsp_head_nxt_s = col_rd_data;
        end else begin
            rsp_head_nxt_s = rsp_mem_r[rsp_rd_ptr_nxt_s];
        end

        busy_nxt_s = (req_cnt_nxt_s != QCW'(0)) || issue_rd_s || rd_p1_r ||
                     (rsp_cnt_nxt_s != RCW'(0)) || issue_wr_s;

        req_ovf_s = push_s && (req_cnt_r == QCW'(REQ_DEPTH));
        rsp_ovf_s = cap_s && (rsp_cnt_r == RCW'(RSP_DEPTH)) && !pop_s;
    end

    // Request FIFO: storage, pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REQ_DEPTH; i++) begin
                req_mem_r[i] <= '{we: 1'b0, addr: {AW{1'b0}}, wdata: 32'h0000_0000, be: 4'b0000};
            end
            req_wr_ptr_r <= {QPW{1'b0}};
            req_rd_ptr_r <= {QPW{1'b0}};
            req_cnt_r    <= {QCW{1'b0}};
            req_ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                req_mem_r[req_wr_ptr_r] <= push_data_s;
                req_wr_ptr_r            <= req_wr_ptr_r + QPW'(1);
            end else begin
                req_wr_ptr_r <= req_wr_ptr_r;
            end
            if (issue_s) begin
                req_rd_ptr_r <= req_rd_ptr_r + QPW'(1);
            end else begin
                req_rd_ptr_r <= req_rd_ptr_r;
            end
            req_cnt_r   <= req_cnt_nxt_s;
            req_ready_r <= (req_cnt_nxt_s != QCW'(REQ_DEPTH));
        end
    end

    // Issue stage: present the popped head to the columns and track reads in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_addr_r    <= {AW{1'b0}};
            col_wr_data_r <= 32'h0000_0000;
            col_byte_en_r <= 4'b0000;
            rd_p1_r       <= 1'b0;
            rd_p2_r       <= 1'b0;
        end else begin
            if (issue_wr_s) begin
                col_addr_r    <= head_s.addr;
                col_wr_data_r <= head_s.wdata;
                col_byte_en_r <= head_s.be;
            end else if (issue_rd_s) begin
                col_addr_r    <= head_s.addr;
                col_wr_data_r <= col_wr_data_r;
                col_byte_en_r <= 4'b0000;
            end else begin
                // Idle: address and data hold, strobes drop.
                col_addr_r    <= col_addr_r;
                col_wr_data_r <= col_wr_data_r;
                col_byte_en_r <= 4'b0000;
            end
            rd_p1_r <= issue_rd_s;
            rd_p2_r <= rd_p1_r;
        end
    end

    // Response buffer: capture column data, pop on handshake, registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                rsp_mem_r[i] <= 32'h0000_0000;
            end
            rsp_wr_ptr_r <= {RPW{1'b0}};
            rsp_rd_ptr_r <= {RPW{1'b0}};
            rsp_cnt_r    <= {RCW{1'b0}};
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 32'h0000_0000;
        end else begin
            if (cap_s) begin
                rsp_mem_r[rsp_wr_ptr_r] <= col_rd_data;
                rsp_wr_ptr_r            <= rsp_ptr_inc(rsp_wr_ptr_r);
            end else begin
                rsp_wr_ptr_r <= rsp_wr_ptr_r;
            end
            rsp_rd_ptr_r <= rsp_rd_ptr_nxt_s;
            rsp_cnt_r    <= rsp_cnt_nxt_s;
            rsp_valid_r  <= (rsp_cnt_nxt_s != RCW'(0));
            if (rsp_cnt_nxt_s != RCW'(0)) begin
                rsp_rdata_r <= rsp_head_nxt_s;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    // Activity flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign req_ready   = req_ready_r;
    assign col_addr    = col_addr_r;
    assign col_wr_data = col_wr_data_r;
    assign col_byte_en = col_byte_en_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign busy        = busy_r;

    memory_col_ctrl_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_ovf (req_ovf_s),
        .rsp_ovf (rsp_ovf_s)
    );

endmodule
